pc_fetch_unit: RTL and testbench

- Program-counter register plus instruction-fetch sequencer for the single-cycle RV32I core.
- Consumes the 2-bit pc_control select produced by the PC-source control logic and computes the next PC.
- Fetches each instruction through a valid/ready request and valid response handshake to instruction memory, then presents it to the datapath.
- Holds the retired-instruction counter and traps on a misaligned control-flow target.

---
 rtl/rv32_pkg.sv | 19 +
 rtl/pc_next_calc.sv | 34 +++
 rtl/pc_fetch_unit.sv | 121 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions: next-PC selects, fetch FSM states, canonical NOP.
// Imported by the fetch unit and its next-PC calculator.
package rv32_pkg;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JAL    = 2'b10;
    localparam logic [1:0] PC_SEL_JALR   = 2'b11;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'b00,
        ST_WAIT = 2'b01,
        ST_EXEC = 2'b10,
        ST_HALT = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC target selection and word-alignment check.
// Purely combinational, no backpressure.
module pc_next_calc
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [1:0]      pc_control_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_data_i,
    output logic [XLEN-1:0] target_o,
    output logic            misaligned_o
);

    logic [XLEN-1:0] jalr_sum;

    assign jalr_sum = rs1_data_i + imm_i;

    always_comb begin
        target_o = pc_i + XLEN'(4);
        unique case (pc_control_i)
            PC_SEL_PLUS4:  target_o = pc_i + XLEN'(4);
            PC_SEL_BRANCH: target_o = pc_i + imm_i;
            PC_SEL_JAL:    target_o = pc_i + imm_i;
            PC_SEL_JALR:   target_o = {jalr_sum[XLEN-1:1], 1'b0};
            default:       target_o = pc_i + XLEN'(4);
        endcase
    end

    // jalr clears bit 0, so only bit 1 can still trip it on that path
    assign misaligned_o = |target_o[1:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and REQ/WAIT/EXEC fetch sequencer; 3 cycles per instruction with zero-wait memory.
// Holds the request address while imem_req_ready is low and holds instr until instr_ack.
module pc_fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      pc_control,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            instr_ack,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic            misaligned_trap,
    output logic [XLEN-1:0] trap_addr,
    output logic [31:0]     instret
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            trap_q, trap_d;
    logic [XLEN-1:0] trap_addr_q, trap_addr_d;
    logic [31:0]     instret_q, instret_d;
    logic [XLEN-1:0] target;
    logic            target_misaligned;
    logic            req_vld;
    logic            instr_vld;

    pc_next_calc #(
        .XLEN(XLEN)
    ) u_next_calc (
        .pc_i         (pc_q),
        .pc_control_i (pc_control),
        .imm_i        (imm),
        .rs1_data_i   (rs1_data),
        .target_o     (target),
        .misaligned_o (target_misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_VECTOR;
            instr_q     <= NOP_INSTR;
            trap_q      <= 1'b0;
            trap_addr_q <= '0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            trap_q      <= trap_d;
            trap_addr_q <= trap_addr_d;
            instret_q   <= instret_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        trap_d      = trap_q;
        trap_addr_d = trap_addr_q;
        instret_d   = instret_q;
        req_vld     = 1'b0;
        instr_vld   = 1'b0;
        unique case (state_q)
            ST_REQ: begin
                req_vld = 1'b1;
                if (imem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    instr_d = imem_rsp_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                instr_vld = 1'b1;
                if (instr_ack) begin
                    instret_d = instret_q + 32'd1;
                    if (target_misaligned) begin
                        trap_d      = 1'b1;
                        trap_addr_d = target;
                        state_d     = ST_HALT;
                    end else begin
                        pc_d    = target;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: state_d = ST_HALT;
        endcase
    end

    // State resets to REQ, so mask the request while reset is still held
    assign imem_req_valid  = req_vld & rst_n;
    assign imem_addr       = pc_q;
    assign pc              = pc_q;
    assign pc_plus4        = pc_q + XLEN'(4);
    assign instr           = instr_q;
    assign instr_valid     = instr_vld;
    assign misaligned_trap = trap_q;
    assign trap_addr       = trap_addr_q;
    assign instret         = instret_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed-vector bench for pc_fetch_unit with RESET_VECTOR=0x100.
module tb_pc_fetch_unit;

    localparam logic [31:0] RV  = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [1:0]  pc_control;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic        instr_ack;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic        misaligned_trap;
    logic [31:0] trap_addr;
    logic [31:0] instret;

    int n_vec  = 0;
    int n_miss = 0;
    int req_cnt = 0;
    int r0;

    pc_fetch_unit #(
        .RESET_VECTOR(RV),
        .XLEN(32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_control      (pc_control),
        .imm             (imm),
        .rs1_data        (rs1_data),
        .instr_ack       (instr_ack),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .misaligned_trap (misaligned_trap),
        .trap_addr       (trap_addr),
        .instret         (instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (imem_req_valid && imem_req_ready) req_cnt <= req_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // zero-wait fetch: REQ accepted, response next cycle, leaves the unit in EXEC
    task automatic fetch(input logic [31:0] word);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word;
        tick();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic ack(input logic [1:0] ctl, input logic [31:0] im, input logic [31:0] r1);
        pc_control = ctl;
        imm        = im;
        rs1_data   = r1;
        instr_ack  = 1'b1;
        tick();
        instr_ack  = 1'b0;
        pc_control = 2'b00;
        imm        = '0;
        rs1_data   = '0;
    endtask

    initial begin
        rst_n          = 1'b0;
        pc_control     = 2'b00;
        imm            = '0;
        rs1_data       = '0;
        instr_ack      = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        @(negedge clk);
        @(negedge clk);

        chk("rst_pc", pc, RV);
        chk("rst_instr", instr, NOP);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_trap", {31'b0, misaligned_trap}, 32'd0);
        chk("rst_trap_addr", trap_addr, 32'd0);
        chk("rst_instret", instret, 32'd0);

        rst_n = 1'b1;
        #1;
        chk("post_rst_req_valid", {31'b0, imem_req_valid}, 32'd1);

        // sequential fetch 100, 104, 108
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("seq_addr%0d", i), imem_addr, RV + 32'(4 * i));
            fetch(32'h0010_0093 + 32'(i));
            chk($sformatf("seq_ivld%0d", i), {31'b0, instr_valid}, 32'd1);
            chk($sformatf("seq_instr%0d", i), instr, 32'h0010_0093 + 32'(i));
            ack(2'b00, 32'h0, 32'h0);
        end
        chk("seq_addr3", imem_addr, 32'h0000_010C);
        chk("seq_instret", instret, 32'd3);

        // jal 0x10C + 0xF4 -> 0x200
        fetch(32'h0F40_006F);
        ack(2'b10, 32'h0000_00F4, 32'hDEAD_0000);
        chk("jal_addr", imem_addr, 32'h0000_0200);

        // branch at 0x200 with imm=-8
        fetch(32'hFE00_0CE3);
        chk("br_plus4", pc_plus4, 32'h0000_0204);
        ack(2'b01, 32'hFFFF_FFF8, 32'h0);
        chk("br_addr", imem_addr, 32'h0000_01F8);
        chk("br_instret", instret, 32'd5);

        // stalled request with a spurious response and a stray ack in REQ
        r0 = req_cnt;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
            if (i == 3) begin
                instr_ack  = 1'b1;
                pc_control = 2'b10;
                imm        = 32'h40;
            end
            tick();
            imem_rsp_valid = 1'b0;
            instr_ack      = 1'b0;
            pc_control     = 2'b00;
            imm            = '0;
            chk($sformatf("stall_addr%0d", i), imem_addr, 32'h0000_01F8);
            chk($sformatf("stall_rvld%0d", i), {31'b0, imem_req_valid}, 32'd1);
        end
        chk("stall_instr_held", instr, 32'hFE00_0CE3);
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0BAD;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        chk("wait_rvld", {31'b0, imem_req_valid}, 32'd0);
        chk("same_cycle_rsp_drop", instr, 32'hFE00_0CE3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("wait_ivld%0d", i), {31'b0, instr_valid}, 32'd0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h00A0_0093;
        tick();
        imem_rsp_valid = 1'b0;
        chk("late_rsp_instr", instr, 32'h00A0_0093);
        chk("late_rsp_ivld", {31'b0, instr_valid}, 32'd1);
        chk("stall_single_req", 32'(req_cnt - r0), 32'd1);
        ack(2'b00, 32'h0, 32'h0);
        chk("stall_next_addr", imem_addr, 32'h0000_01FC);

        // instret wrap
        fetch(32'h0000_0013);
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        chk("wrap_preload", instret, 32'hFFFF_FFFF);
        ack(2'b00, 32'h0, 32'h0);
        chk("wrap_instret", instret, 32'd0);
        chk("wrap_addr", imem_addr, 32'h0000_0200);

        // reset while in WAIT, then a late response
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pc", pc, RV);
        chk("mid_rst_instr", instr, NOP);
        chk("mid_rst_ivld", {31'b0, instr_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        tick();
        imem_rsp_valid = 1'b0;
        chk("late_drop_instr", instr, NOP);
        chk("late_drop_rvld", {31'b0, imem_req_valid}, 32'd1);
        chk("late_drop_addr", imem_addr, RV);
        r0 = req_cnt;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("restart_req", 32'(req_cnt - r0), 32'd1);

        // jalr to a misaligned target
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0020_8067;
        tick();
        imem_rsp_valid = 1'b0;
        ack(2'b11, 32'h0000_0002, 32'h0000_1001);
        chk("trap_flag", {31'b0, misaligned_trap}, 32'd1);
        chk("trap_addr", trap_addr, 32'h0000_1002);
        chk("trap_pc", pc, RV);
        chk("trap_instret", instret, 32'd1);
        r0 = req_cnt;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("halt_rvld%0d", i), {31'b0, imem_req_valid}, 32'd0);
            chk($sformatf("halt_ivld%0d", i), {31'b0, instr_valid}, 32'd0);
        end
        imem_req_ready = 1'b0;
        chk("halt_no_req", 32'(req_cnt - r0), 32'd0);
        chk("halt_trap_sticky", {31'b0, misaligned_trap}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
